// File: rtl/delay_line.sv
// Programmable delay line: circular history buffer with a runtime-selected
// delay, fill-count gating and clear on flush or delay change.
module delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DELAY  = 4,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic [SEL_WIDTH-1:0]  delay_sel,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  primed
);

    localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int SW = SEL_WIDTH;
    localparam logic [SW-1:0] MAXD = SW'(MAX_DELAY);
    localparam logic [AW-1:0] LAST = AW'(MAX_DELAY - 1);

    logic [DATA_WIDTH:0] mem [MAX_DELAY];

    logic [SW-1:0]       d_eff;
    logic [SW-1:0]       d_reg;
    logic [SW-1:0]       fill;
    logic [SW-1:0]       fill_nxt;
    logic [SW-1:0]       nxt_ext;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       wr_nxt;
    logic [AW-1:0]       rd_idx;
    logic [DATA_WIDTH:0] wr_ent;
    logic [DATA_WIDTH:0] rd_ent;
    logic                clr;
    logic                prm_nxt;

    always_comb begin
        d_eff = delay_sel;
        if (delay_sel == '0) begin
            d_eff = SW'(1);
        end else if (delay_sel > MAXD) begin
            d_eff = MAXD;
        end

        wr_nxt  = (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
        nxt_ext = SW'(wr_nxt);

        // Index of the sample that must appear next cycle; modular wrap
        // without relying on a power-of-two depth.
        if (nxt_ext >= d_eff) begin
            rd_idx = AW'(nxt_ext - d_eff);
        end else begin
            rd_idx = AW'(nxt_ext + MAXD - d_eff);
        end

        wr_ent = {i_valid, i_data};
        // D=1 reads the slot being written this cycle: bypass it.
        rd_ent = (rd_idx == wr_ptr) ? wr_ent : mem[rd_idx];

        clr = flush | (d_eff != d_reg);

        if (clr) begin
            fill_nxt = '0;
        end else if (fill == MAXD) begin
            fill_nxt = fill;
        end else begin
            fill_nxt = fill + SW'(1);
        end

        prm_nxt = (fill_nxt >= d_eff);
    end

    always_ff @(posedge clk) begin
        mem[wr_ptr] <= wr_ent;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            fill    <= '0;
            d_reg   <= d_eff;
            primed  <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            wr_ptr  <= wr_nxt;
            fill    <= fill_nxt;
            d_reg   <= d_eff;
            primed  <= prm_nxt;
            o_valid <= prm_nxt & rd_ent[DATA_WIDTH];
            o_data  <= prm_nxt ? rd_ent[DATA_WIDTH-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_delay_line.sv
// Randomized and directed bench for delay_line against a cycle-history
// reference model.
module tb_delay_line;

    logic       clk;
    logic       reset;
    logic [7:0] i_data;
    logic       i_valid;
    logic [2:0] delay_sel;
    logic       flush;
    logic [7:0] o_data;
    logic       o_valid;
    logic       primed;

    int n_vec;
    int n_err;

    logic [8:0] hist [$];
    int         since;
    int         dprev;

    delay_line #(
        .DATA_WIDTH(8),
        .MAX_DELAY (4),
        .SEL_WIDTH (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .delay_sel(delay_sel),
        .flush    (flush),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .primed   (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff(int s);
        if (s == 0) return 1;
        if (s > 4) return 4;
        return s;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic do_reset(int sel);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_primed", 32'(primed), 32'd0);
        delay_sel = 3'(sel);
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        hist.delete();
        since = 0;
        dprev = eff(sel);
    endtask

    task automatic step(int sel, bit fl, bit v, logic [7:0] d);
        int  de;
        bit  clr;
        bit  ep;
        logic [8:0] smp;
        delay_sel = 3'(sel);
        flush     = fl;
        i_valid   = v;
        i_data    = d;
        de  = eff(sel);
        clr = fl || (de != dprev);
        hist.push_back({v, d});
        @(posedge clk);
        #1;
        since = clr ? 0 : since + 1;
        ep    = (since >= de);
        smp   = ep ? hist[hist.size() - de] : 9'd0;
        dprev = de;
        chk("primed", 32'(primed), 32'(ep));
        chk("o_valid", 32'(o_valid), 32'(smp[8]));
        chk("o_data", 32'(o_data), 32'(smp[7:0]));
    endtask

    initial begin
        int sel;
        bit vp [4];
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        i_data    = '0;
        i_valid   = 1'b0;
        delay_sel = 3'd2;
        flush     = 1'b0;
        since     = 0;
        dprev     = 2;

        do_reset(2);
        for (int i = 0; i < 10; i++) step(2, 0, 1, 8'(i + 1));
        for (int i = 10; i < 18; i++) step(4, 0, 1, 8'(i + 1));

        do_reset(7);
        for (int i = 0; i < 8; i++) step(7, 0, 1, 8'(i + 40));
        do_reset(0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(i + 60));

        vp = '{1, 0, 1, 1};
        do_reset(3);
        for (int i = 0; i < 20; i++) step(3, 0, vp[i % 4], 8'(i + 80));

        do_reset(1);
        for (int i = 0; i < 12; i++) step(1, i == 8, 1, 8'(i + 100));

        do_reset(2);
        for (int i = 0; i < 6; i++) step(2, 0, 1, 8'(i + 120));
        step(3, 1, 1, 8'd130);
        for (int i = 0; i < 6; i++) step(3, 0, 1, 8'(i + 131));

        sel = 2;
        do_reset(sel);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(15) == 0) sel = int'($urandom_range(7));
            if ($urandom_range(199) == 0) do_reset(sel);
            step(sel, $urandom_range(19) == 0, 1'($urandom),
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
